// File: rtl/fetch_pc_sequencer.sv
// Fetch PC sequencer: owns the PC, issues in-order fetches, pairs responses with their PCs.
// Optional build macro FETCH_MISALIGN_CHK_EN adds misaligned-redirect halt and o_misalign.
module fetch_pc_sequencer #(
  parameter int unsigned     XLEN            = 32,
  parameter int unsigned     IMDATALEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int unsigned     MAX_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 o_fetch_valid,
  input  logic                 i_fetch_ready,
  output logic [XLEN-1:0]      o_fetch_addr,
  input  logic                 i_instr_valid,
  output logic                 o_instr_ready,
  input  logic [IMDATALEN-1:0] i_instr_data,
  input  logic                 i_redirect_valid,
  input  logic [XLEN-1:0]      i_redirect_addr,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic                 o_misalign,
`endif
  output logic                 o_dec_valid,
  input  logic                 i_dec_ready,
  output logic [IMDATALEN-1:0] o_dec_instr,
  output logic [XLEN-1:0]      o_dec_pc
);

  localparam int unsigned PtrW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CntW = PtrW + 1;

  logic [XLEN-1:0]            r_pc;
  logic [XLEN-1:0]            r_stale_addr;
  logic [XLEN-1:0]            r_fifo_pc [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] r_fifo_kill;
  logic [PtrW-1:0]            r_wr_ptr;
  logic [PtrW-1:0]            r_rd_ptr;
  logic [CntW-1:0]            r_count;
  logic                       r_held;
  logic                       r_held_stale;

  logic            w_halt;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_head_kill;
  logic [XLEN-1:0] w_redirect_target;

`ifdef FETCH_MISALIGN_CHK_EN
  logic r_halt;
  logic r_misalign;
  logic w_misaligned;

  assign w_misaligned      = i_redirect_addr[1:0] != 2'b00;
  assign w_halt            = r_halt;
  assign w_redirect_target = i_redirect_addr;
  assign o_misalign        = r_misalign;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_halt     <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= i_redirect_valid & w_misaligned;
      if (i_redirect_valid) r_halt <= w_misaligned;
    end
  end
`else
  assign w_halt            = 1'b0;
  assign w_redirect_target = i_redirect_addr & ~XLEN'(3);
`endif

  assign w_full  = r_count == CntW'(MAX_OUTSTANDING);
  assign w_empty = r_count == '0;

  // A request already on the bus stays there until accepted, regardless of full/halt.
  assign o_fetch_valid = ~rst & (r_held | (~w_full & ~w_halt));
  assign o_fetch_addr  = r_held_stale ? r_stale_addr : r_pc;
  assign w_push        = o_fetch_valid & i_fetch_ready;

  assign w_head_kill = r_fifo_kill[r_rd_ptr];
  assign o_dec_instr = i_instr_data;
  assign o_dec_pc    = r_fifo_pc[r_rd_ptr];

  always_comb begin
    o_instr_ready = 1'b0;
    o_dec_valid   = 1'b0;
    if (!rst && !w_empty) begin
      if (w_head_kill) begin
        o_instr_ready = 1'b1;
      end else begin
        // A response racing a redirect is consumed but never reaches decode.
        o_dec_valid   = i_instr_valid & ~i_redirect_valid;
        o_instr_ready = i_dec_ready | i_redirect_valid;
      end
    end
  end

  assign w_pop = i_instr_valid & o_instr_ready;

  always_ff @(posedge clk) begin
    if (w_push) r_fifo_pc[r_wr_ptr] <= o_fetch_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_stale_addr <= '0;
      r_fifo_kill  <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_held       <= 1'b0;
      r_held_stale <= 1'b0;
    end else begin
      r_held <= o_fetch_valid & ~i_fetch_ready;

      // Later write to the pushed slot overrides the blanket kill for that bit.
      if (i_redirect_valid) r_fifo_kill <= '1;
      if (w_push) begin
        r_fifo_kill[r_wr_ptr] <= r_held_stale | i_redirect_valid;
        r_wr_ptr              <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);

      if (w_push) begin
        r_held_stale <= 1'b0;
      end else if (i_redirect_valid && o_fetch_valid) begin
        r_held_stale <= 1'b1;
        if (!r_held_stale) r_stale_addr <= r_pc;
      end

      if (i_redirect_valid) begin
        r_pc <= w_redirect_target;
      end else if (w_push && !r_held_stale) begin
        r_pc <= r_pc + XLEN'(4);
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer: queue-based reference model checked every cycle,
// plus literal expectations per scenario.
module tb_fetch_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fr = 1'b0;
  logic        iv = 1'b0;
  logic [31:0] idata = '0;
  logic        rv = 1'b0;
  logic [31:0] raddr = '0;
  logic        dr = 1'b0;

  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic        instr_ready;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_pc_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .o_fetch_valid    (fetch_valid),
    .i_fetch_ready    (fr),
    .o_fetch_addr     (fetch_addr),
    .i_instr_valid    (iv),
    .o_instr_ready    (instr_ready),
    .i_instr_data     (idata),
    .i_redirect_valid (rv),
    .i_redirect_addr  (raddr),
`ifdef FETCH_MISALIGN_CHK_EN
    .o_misalign       (misalign),
`endif
    .o_dec_valid      (dec_valid),
    .i_dec_ready      (dr),
    .o_dec_instr      (dec_instr),
    .o_dec_pc         (dec_pc)
  );

  // Reference model: in-flight requests as a queue of (address, killed).
  logic [31:0] m_pc = '0;
  logic [31:0] q_addr[$];
  bit          q_kill[$];
  bit          m_pend = 0;
  bit          m_pend_stale = 0;
  logic [31:0] m_pend_addr = '0;
  bit          m_halt = 0;
  bit          m_mis = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_out(output bit e_fv, output logic [31:0] e_fa, output bit e_ir,
                           output bit e_dv, output logic [31:0] e_pc);
    e_fv = m_pend || (q_addr.size() < 4 && !m_halt);
    e_fa = m_pend ? m_pend_addr : m_pc;
    e_ir = 0;
    e_dv = 0;
    e_pc = '0;
    if (q_addr.size() != 0) begin
      e_pc = q_addr[0];
      if (q_kill[0]) begin
        e_ir = 1;
      end else begin
        e_dv = iv && !rv;
        e_ir = dr || rv;
      end
    end
  endtask

  task automatic model_step();
    bit          fv, ir, dv, hs;
    logic [31:0] fa, hp, tgt;
    if (rst) begin
      m_pc = '0;
      q_addr.delete();
      q_kill.delete();
      m_pend = 0;
      m_pend_stale = 0;
      m_halt = 0;
      m_mis = 0;
    end else begin
      model_out(fv, fa, ir, dv, hp);
      hs = fv && fr;
`ifdef FETCH_MISALIGN_CHK_EN
      tgt = raddr;
      m_mis = rv && (raddr % 4 != 0);
      if (rv) m_halt = (raddr % 4 != 0);
`else
      tgt = raddr - (raddr % 4);
`endif
      if (iv && ir) begin
        void'(q_addr.pop_front());
        void'(q_kill.pop_front());
      end
      if (rv) foreach (q_kill[i]) q_kill[i] = 1;
      if (hs) begin
        q_addr.push_back(fa);
        q_kill.push_back(m_pend_stale || rv);
        if (!m_pend_stale) m_pc = m_pc + 4;
        m_pend = 0;
        m_pend_stale = 0;
      end else if (fv) begin
        m_pend = 1;
        m_pend_addr = fa;
        if (rv) m_pend_stale = 1;
      end
      if (rv) m_pc = tgt;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison against the model, mid-cycle.
  initial forever begin
    bit          e_fv, e_ir, e_dv;
    logic [31:0] e_fa, e_pc;
    @(negedge clk);
    if (rst) begin
      chk("rst_fetch_valid", 32'(fetch_valid), 32'(0));
      chk("rst_instr_ready", 32'(instr_ready), 32'(0));
      chk("rst_dec_valid", 32'(dec_valid), 32'(0));
    end else begin
      model_out(e_fv, e_fa, e_ir, e_dv, e_pc);
      chk("fetch_valid", 32'(fetch_valid), 32'(e_fv));
      if (e_fv) chk("fetch_addr", fetch_addr, e_fa);
      chk("instr_ready", 32'(instr_ready), 32'(e_ir));
      chk("dec_valid", 32'(dec_valid), 32'(e_dv));
      if (e_dv) begin
        chk("dec_pc", dec_pc, e_pc);
        chk("dec_instr", dec_instr, idata);
      end
`ifdef FETCH_MISALIGN_CHK_EN
      chk("misalign", 32'(misalign), 32'(m_mis));
`endif
    end
  end

  task automatic step(input bit f, input bit v, input logic [31:0] d, input bit r,
                      input logic [31:0] ra, input bit de);
    @(posedge clk);
    #1;
    rst = 0;
    fr = f;
    iv = v;
    idata = d;
    rv = r;
    raddr = ra;
    dr = de;
    @(negedge clk);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      rst = 1;
      fr = 0;
      iv = 0;
      idata = '0;
      rv = 0;
      raddr = '0;
      dr = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    // 1: streaming, response one cycle after each request.
    do_reset();
    step(1, 0, 0, 0, 0, 1);
    chk("t1_first_valid", 32'(fetch_valid), 32'(1));
    chk("t1_first_addr", fetch_addr, 32'h0);
    for (int k = 0; k < 8; k++) begin
      step(1, 1, 32'hD000_0000 | k, 0, 0, 1);
      chk("t1_dec_valid", 32'(dec_valid), 32'(1));
      chk("t1_dec_pc", dec_pc, 32'(4 * k));
      chk("t1_fetch_addr", fetch_addr, 32'(4 * (k + 1)));
    end
    step(0, 1, 32'hD000_0008, 0, 0, 1);
    chk("t1_last_pc", dec_pc, 32'h20);

    // 2: no responses, exactly four requests then stall.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, 0, 0, 1);
      chk("t2_valid", 32'(fetch_valid), 32'(1));
      chk("t2_addr", fetch_addr, 32'(4 * k));
    end
    step(1, 0, 0, 0, 0, 1);
    chk("t2_full_a", 32'(fetch_valid), 32'(0));
    step(1, 0, 0, 0, 0, 1);
    chk("t2_full_b", 32'(fetch_valid), 32'(0));
    step(1, 1, 32'hAAAA_0000, 0, 0, 1);
    chk("t2_pop_valid", 32'(fetch_valid), 32'(0));
    chk("t2_pop_pc", dec_pc, 32'h0);
    step(1, 0, 0, 0, 0, 1);
    chk("t2_resume_valid", 32'(fetch_valid), 32'(1));
    chk("t2_resume_addr", fetch_addr, 32'h10);

    // 3: redirect with three in flight (third pushed in the redirect cycle).
    do_reset();
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 32'h100, 1);
    for (int k = 0; k < 3; k++) begin
      step(k < 2, 1, 32'hBBBB_0000 | k, 0, 0, 1);
      chk("t3_dropped", 32'(dec_valid), 32'(0));
      chk("t3_drop_ready", 32'(instr_ready), 32'(1));
    end
    step(0, 1, 32'hBBBB_0100, 0, 0, 1);
    chk("t3_first_pc", dec_pc, 32'h100);
    chk("t3_first_valid", 32'(dec_valid), 32'(1));
    step(0, 1, 32'hBBBB_0104, 0, 0, 1);
    chk("t3_second_pc", dec_pc, 32'h104);
    step(0, 1, 32'hBBBB_0108, 0, 0, 1);

    // 4: held request at 8 survives a redirect to 0x40 and is then killed.
    do_reset();
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("t4_held_addr", fetch_addr, 32'h8);
    step(0, 0, 0, 1, 32'h40, 1);
    chk("t4_redir_addr", fetch_addr, 32'h8);
    step(0, 0, 0, 0, 0, 1);
    chk("t4_stale_addr", fetch_addr, 32'h8);
    chk("t4_stale_valid", 32'(fetch_valid), 32'(1));
    step(1, 0, 0, 0, 0, 1);
    chk("t4_hs_addr", fetch_addr, 32'h8);
    step(1, 0, 0, 0, 0, 1);
    chk("t4_new_addr", fetch_addr, 32'h40);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 32'hCCCC_0000 | k, 0, 0, 1);
      chk("t4_killed", 32'(dec_valid), 32'(0));
    end
    step(0, 1, 32'hCCCC_0040, 0, 0, 1);
    chk("t4_dec_pc", dec_pc, 32'h40);
    chk("t4_dec_valid", 32'(dec_valid), 32'(1));

    // 5: decode backpressure holds the response in place.
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 32'h1234_5678, 0, 0, 0);
      chk("t5_ready_low", 32'(instr_ready), 32'(0));
      chk("t5_dec_pc", dec_pc, 32'h0);
      chk("t5_dec_instr", dec_instr, 32'h1234_5678);
    end
    step(0, 1, 32'h1234_5678, 0, 0, 1);
    chk("t5_ready_high", 32'(instr_ready), 32'(1));
    step(0, 0, 0, 0, 0, 1);
    chk("t5_popped", 32'(dec_valid), 32'(0));

`ifdef FETCH_MISALIGN_CHK_EN
    // 6: misaligned redirect halts fetch until an aligned redirect.
    do_reset();
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 32'h102, 1);
    step(1, 0, 0, 0, 0, 1);
    chk("t6_halt_valid", 32'(fetch_valid), 32'(0));
    chk("t6_misalign_hi", 32'(misalign), 32'(1));
    step(1, 0, 0, 0, 0, 1);
    chk("t6_misalign_lo", 32'(misalign), 32'(0));
    chk("t6_still_halt", 32'(fetch_valid), 32'(0));
    step(1, 0, 0, 1, 32'h200, 1);
    chk("t6_redir_valid", 32'(fetch_valid), 32'(0));
    step(1, 0, 0, 0, 0, 1);
    chk("t6_resume_valid", 32'(fetch_valid), 32'(1));
    chk("t6_resume_addr", fetch_addr, 32'h200);
`else
    // 7: response in redirect cycle dropped; target low bits cleared.
    do_reset();
    step(1, 0, 0, 0, 0, 1);
    step(0, 1, 32'hEEEE_0000, 1, 32'h203, 1);
    chk("t7_drop_valid", 32'(dec_valid), 32'(0));
    chk("t7_drop_ready", 32'(instr_ready), 32'(1));
    step(1, 0, 0, 0, 0, 1);
    chk("t7_stale_addr", fetch_addr, 32'h4);
    step(1, 0, 0, 0, 0, 1);
    chk("t7_target_addr", fetch_addr, 32'h200);
`endif

    step(0, 0, 0, 0, 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
